// File: rtl/registrador_de_instrucoes_fila.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO; `next` moves the queue head into IR (1-cycle latency).
// Backpressure: a push into a full queue is dropped and latched in sticky `overflow`, unless it coincides with a pop.
module registrador_de_instrucoes_fila #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       load,
  input  logic [DATA_W-1:0]          entrada_instrucao,
  input  logic                       next,
  input  logic                       flush,
  input  logic                       clr_opcode,
  input  logic                       ei,
  output logic [OPC_W-1:0]           opcode,
  output logic [DATA_W-1:0]          saida_barramento,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int OPR_W = DATA_W - OPC_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_full, r_empty;
  logic [DATA_W-1:0] r_ir;
  logic              r_valid;
  logic              r_overflow;

  logic              w_pop, w_push, w_drop;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] w_ir_nxt;
  logic              w_valid_nxt;

  // A full queue is never empty, so a pop on the same edge always frees the slot for the push.
  assign w_pop       = next && !r_empty;
  assign w_push      = load && (!r_full || w_pop);
  assign w_drop      = load && r_full && !w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_valid;
    if (next) begin
      w_ir_nxt    = r_empty ? '0 : r_mem[r_rptr];
      w_valid_nxt = !r_empty;
    end
    // Opcode clear applies after the fetch so a same-edge next yields a fresh word with opcode zeroed.
    if (clr_opcode)
      w_ir_nxt[DATA_W-1:OPR_W] = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ir       <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_drop) r_overflow <= 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_ir    <= w_ir_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (!clr && !flush && w_push)
      r_mem[r_wptr] <= entrada_instrucao;
  end

  assign opcode           = r_ir[DATA_W-1:OPR_W];
  assign saida_barramento = ei ? {{OPC_W{1'b0}}, r_ir[OPR_W-1:0]} : '0;
  assign valid            = r_valid;
  assign full             = r_full;
  assign empty            = r_empty;
  assign count            = r_count;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_registrador_de_instrucoes_fila.sv
// Directed-vector bench for the prefetching instruction register (DATA_W=8, OPC_W=4, DEPTH=4).
module tb_registrador_de_instrucoes_fila;

  logic       clk = 1'b0;
  logic       clr, load, next, flush, clr_opcode, ei;
  logic [7:0] entrada_instrucao;
  logic [3:0] opcode;
  logic [7:0] saida_barramento;
  logic       valid, full, empty, overflow;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  registrador_de_instrucoes_fila #(.DATA_W(8), .OPC_W(4), .DEPTH(4)) dut (
    .clk(clk), .clr(clr), .load(load), .entrada_instrucao(entrada_instrucao),
    .next(next), .flush(flush), .clr_opcode(clr_opcode), .ei(ei),
    .opcode(opcode), .saida_barramento(saida_barramento), .valid(valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    load = 1'b1; entrada_instrucao = w;
    step();
    load = 1'b0;
  endtask

  task automatic pop();
    next = 1'b1;
    step();
    next = 1'b0;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; next = 1'b0; flush = 1'b0; clr_opcode = 1'b0; ei = 1'b1;
    entrada_instrucao = 8'h00;
    step();
    chk("rst_opcode", opcode, 4'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_bus", saida_barramento, 8'h00);

    // Single fetch
    clr = 1'b0; ei = 1'b0;
    push(8'hB3);
    chk("b3_count", count, 3'd1);
    pop();
    ei = 1'b1; #1;
    chk("b3_opcode", opcode, 4'hB);
    chk("b3_bus", saida_barramento, 8'h03);
    chk("b3_valid", valid, 1'b1);
    chk("b3_empty", empty, 1'b1);

    // Fill, overflow, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 3'd4);
    chk("fill_ovf_clear", overflow, 1'b0);
    push(8'h55);
    chk("drop_ovf", overflow, 1'b1);
    chk("drop_count", count, 3'd4);
    pop(); chk("drain_op1", opcode, 4'h1); chk("drain_cnt3", count, 3'd3); chk("drain_full0", full, 1'b0);
    pop(); chk("drain_op2", opcode, 4'h2);
    pop(); chk("drain_op3", opcode, 4'h3);
    pop(); chk("drain_op4", opcode, 4'h4);
    chk("drain_empty", empty, 1'b1);
    chk("drain_count", count, 3'd0);

    // Push and pop on a full queue
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    load = 1'b1; entrada_instrucao = 8'h66; next = 1'b1;
    step();
    load = 1'b0; next = 1'b0;
    chk("swap_opcode", opcode, 4'h1);
    chk("swap_bus", saida_barramento, 8'h01);
    chk("swap_count", count, 3'd4);
    chk("swap_full", full, 1'b1);
    chk("swap_ovf", overflow, 1'b1);
    pop(); pop(); pop(); pop();
    chk("swap_tail_op", opcode, 4'h6);
    chk("swap_tail_bus", saida_barramento, 8'h06);
    pop();
    chk("empty_next_valid", valid, 1'b0);
    chk("empty_next_op", opcode, 4'h0);
    chk("empty_next_bus", saida_barramento, 8'h00);

    // Opcode clear
    push(8'hF0);
    pop();
    chk("f0_opcode", opcode, 4'hF);
    clr_opcode = 1'b1;
    step();
    clr_opcode = 1'b0;
    chk("clrop_opcode", opcode, 4'h0);
    chk("clrop_valid", valid, 1'b1);
    chk("clrop_bus_ei1", saida_barramento, 8'h00);
    ei = 1'b0; #1;
    chk("clrop_bus_ei0", saida_barramento, 8'h00);
    ei = 1'b1;
    push(8'hA7);
    next = 1'b1; clr_opcode = 1'b1;
    step();
    next = 1'b0; clr_opcode = 1'b0;
    chk("nextclr_opcode", opcode, 4'h0);
    chk("nextclr_bus", saida_barramento, 8'h07);
    chk("nextclr_valid", valid, 1'b1);

    // Flush overrides load and next
    push(8'h12); push(8'h34);
    chk("preflush_count", count, 3'd2);
    flush = 1'b1; load = 1'b1; next = 1'b1; entrada_instrucao = 8'h56;
    step();
    flush = 1'b0; load = 1'b0; next = 1'b0;
    chk("flush_count", count, 3'd0);
    chk("flush_empty", empty, 1'b1);
    chk("flush_bus", saida_barramento, 8'h07);
    chk("flush_valid", valid, 1'b1);
    chk("flush_ovf", overflow, 1'b1);
    pop();
    chk("postflush_valid", valid, 1'b0);
    chk("postflush_bus", saida_barramento, 8'h00);

    // Reset mid-operation
    push(8'h21); push(8'h32); push(8'h43); push(8'h54);
    pop();
    chk("premid_count", count, 3'd3);
    chk("premid_opcode", opcode, 4'h2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("mid_opcode", opcode, 4'h0);
    chk("mid_valid", valid, 1'b0);
    chk("mid_count", count, 3'd0);
    chk("mid_empty", empty, 1'b1);
    chk("mid_full", full, 1'b0);
    chk("mid_ovf", overflow, 1'b0);
    chk("mid_bus", saida_barramento, 8'h00);
    load = 1'b1; next = 1'b1; entrada_instrucao = 8'hA5;
    step();
    load = 1'b0; next = 1'b0;
    chk("nobypass_valid", valid, 1'b0);
    chk("nobypass_count", count, 3'd1);
    pop();
    chk("a5_opcode", opcode, 4'hA);
    chk("a5_bus", saida_barramento, 8'h05);
    chk("a5_valid", valid, 1'b1);
    chk("a5_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
